// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared FSM state, port indices and ack/err record for dmem_arbiter
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam int PORT_CPU = 0;
  localparam int PORT_DBG = 1;
  typedef struct packed {
    logic ack;
    logic err;
  } resp_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester port of the data-memory arbiter
//   req/we/addr/wdata : requester -> arbiter, held stable until ack
//   ack/err           : one-cycle completion pulse, err marks a rejected access
//   rdata             : read result, held until the next ack to this port
interface dmem_arbiter_if;
  logic req;
  logic we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic ack;
  logic err;
  logic [31:0] rdata;
  modport master (output req, we, addr, wdata, input ack, err, rdata);
  modport slave (input req, we, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: combinational 2-way round-robin picker, one-hot grant
//   req[1:0]   : requests, index = port
//   last_grant : port that won most recently (held by the parent)
//   grant[1:0] : one-hot winner, 0 when nobody requests
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);
  assign grant[PORT_CPU] = req[PORT_CPU] & (!req[PORT_DBG] | last_grant);
  assign grant[PORT_DBG] = req[PORT_DBG] & (!req[PORT_CPU] | !last_grant);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of the single-port data memory between CPU and debug port
//   clk, rst (sync, active-low)
//   m0 (CPU MEM stage), m1 (debug/loader) : requester ports
//   mem_en/mem_we/mem_addr/mem_wdata       : registered strobe and bus to memory
//   mem_rdata                               : read data, valid MEM_LAT cycles after mem_en
//   busy                                    : high outside IDLE, MEM-stage stall source
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int MEM_LAT = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  dmem_arbiter_if.slave       m0,
  dmem_arbiter_if.slave       m1,
  output logic                mem_en,
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata,
  output logic                busy
);
  localparam int CW = $clog2(MEM_LAT + 1);
  state_t state, nxt;
  logic [1:0] grant;
  logic last_grant, win, sel, we_r, we_s, ok;
  logic [31:0] addr_s, wdata_s, rd0, rd1;
  logic [CW-1:0] cnt;
  resp_t r0, r1;
  rr_arb2 u_arb (.req({m1.req, m0.req}), .last_grant(last_grant), .grant(grant));
  assign win = grant[PORT_DBG];
  assign we_s = win ? m1.we : m0.we;
  assign addr_s = win ? m1.addr : m0.addr;
  assign wdata_s = win ? m1.wdata : m0.wdata;
  // word-aligned and inside the memory; rejected accesses never reach mem_en
  assign ok = addr_s[1:0] == 2'b00 && {2'b00, addr_s[31:2]} < 32'(DEPTH);
  assign busy = state != IDLE;
  assign m0.ack = r0.ack;
  assign m0.err = r0.err;
  assign m0.rdata = rd0;
  assign m1.ack = r1.ack;
  assign m1.err = r1.err;
  assign m1.rdata = rd1;
  always_comb begin
    nxt = state;
    if (state == IDLE && |grant) nxt = ok ? ACCESS : RESP;
    else if (state == ACCESS && cnt == '0) nxt = RESP;
    else if (state == RESP) nxt = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      last_grant <= 1'b1;
      sel <= 1'b0;
      we_r <= 1'b0;
      cnt <= '0;
      r0 <= '0;
      r1 <= '0;
      rd0 <= '0;
      rd1 <= '0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      state <= nxt;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      r0 <= '0;
      r1 <= '0;
      if (state == IDLE && |grant) begin
        last_grant <= win;
        sel <= win;
        we_r <= we_s;
        cnt <= CW'(MEM_LAT);
        if (ok) begin
          mem_en <= 1'b1;
          mem_we <= we_s;
          mem_addr <= addr_s[AW+1:2];
          mem_wdata <= wdata_s;
        end else begin
          if (win) r1 <= 2'b11;
          else r0 <= 2'b11;
          if (!we_s && win) rd1 <= '0;
          if (!we_s && !win) rd0 <= '0;
        end
      end
      if (state == ACCESS && cnt != '0) cnt <= cnt - CW'(1);
      // counter at zero marks the cycle in which mem_rdata is valid
      if (state == ACCESS && cnt == '0) begin
        if (sel) r1.ack <= 1'b1;
        else r0.ack <= 1'b1;
        if (!we_r && sel) rd1 <= mem_rdata;
        if (!we_r && !sel) rd0 <= mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a MEM_LAT=2 memory model
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mem_en, mem_we, busy;
  logic [9:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata, p1;
  logic [31:0] mem [1024];
  int tests = 0;
  int fails = 0;
  int en_cnt = 0;
  int en_mark;
  dmem_arbiter_if m0();
  dmem_arbiter_if m1();
  dmem_arbiter #(.DEPTH(1024), .MEM_LAT(2)) dut (
    .clk(clk), .rst(rst), .m0(m0), .m1(m1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );
  always #5 clk = ~clk;
  // two-stage read pipeline: data for an mem_en cycle appears 2 cycles later
  always @(posedge clk) begin
    if (!rst) begin
      mem[4] <= 32'hDEAD_BEEF;
      mem[8] <= 32'h5A5A_0008;
    end else if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    p1 <= mem_en ? mem[mem_addr] : 32'hBAD0_0000;
    mem_rdata <= p1;
    if (mem_en) en_cnt <= en_cnt + 1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic nx(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    m0.req = 1'($urandom_range(0, 1));
    m0.we = 1'($urandom_range(0, 1));
    m0.addr = $urandom;
    m0.wdata = $urandom;
    m1.req = 1'($urandom_range(0, 1));
    m1.we = 1'($urandom_range(0, 1));
    m1.addr = $urandom;
    m1.wdata = $urandom;
    nx(2);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_m0_ackerr", 32'({m0.ack, m0.err}), 0);
    chk("rst_m1_ackerr", 32'({m1.ack, m1.err}), 0);
    chk("rst_m0_rdata", m0.rdata, 0);
    chk("rst_m1_rdata", m1.rdata, 0);
    rst = 1'b1;
    m0.req = 1'b1; m0.we = 1'b0; m0.addr = 32'h10; m0.wdata = 0;
    m1.req = 1'b1; m1.we = 1'b0; m1.addr = 32'h20; m1.wdata = 0;
    chk("idle_busy", 32'(busy), 0);
    nx(1);
    chk("tie0_mem_en", 32'(mem_en), 1);
    chk("tie0_mem_we", 32'(mem_we), 0);
    chk("tie0_mem_addr", 32'(mem_addr), 4);
    chk("tie0_busy", 32'(busy), 1);
    nx(1);
    chk("tie0_en_pulse", 32'(mem_en), 0);
    nx(2);
    chk("rd0_ack", 32'(m0.ack), 1);
    chk("rd0_err", 32'(m0.err), 0);
    chk("rd0_rdata", m0.rdata, 32'hDEAD_BEEF);
    chk("rd0_m1_quiet", 32'({m1.ack, m1.err}), 0);
    chk("rd0_m1_rdata", m1.rdata, 0);
    m0.req = 1'b0;
    nx(1);
    chk("rd0_idle_busy", 32'(busy), 0);
    chk("rd0_ack_pulse", 32'(m0.ack), 0);
    nx(1);
    chk("rd1_mem_en", 32'(mem_en), 1);
    chk("rd1_mem_addr", 32'(mem_addr), 8);
    nx(3);
    chk("rd1_ack", 32'(m1.ack), 1);
    chk("rd1_rdata", m1.rdata, 32'h5A5A_0008);
    chk("rd1_m0_rdata", m0.rdata, 32'hDEAD_BEEF);
    m1.req = 1'b0;
    nx(1);
    m0.req = 1'b1;
    m1.req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      nx(4);
      chk($sformatf("alt%0d_m0_ack", k), 32'(m0.ack), 32'(k % 2 == 0));
      chk($sformatf("alt%0d_m1_ack", k), 32'(m1.ack), 32'(k % 2 == 1));
      if (k == 3) begin
        m0.req = 1'b0;
        m1.req = 1'b0;
      end
      nx(1);
      chk($sformatf("alt%0d_idle", k), 32'(busy), 0);
    end
    m1.req = 1'b1; m1.we = 1'b1; m1.addr = 32'h3FC; m1.wdata = 32'h1234_5678;
    nx(1);
    chk("wr_mem_en", 32'(mem_en), 1);
    chk("wr_mem_we", 32'(mem_we), 1);
    chk("wr_mem_addr", 32'(mem_addr), 255);
    chk("wr_mem_wdata", mem_wdata, 32'h1234_5678);
    nx(3);
    chk("wr_ack", 32'(m1.ack), 1);
    chk("wr_rdata_kept", m1.rdata, 32'h5A5A_0008);
    m1.we = 1'b0;
    nx(2);
    chk("rdb_mem_en", 32'(mem_en), 1);
    chk("rdb_mem_we", 32'(mem_we), 0);
    chk("rdb_mem_addr", 32'(mem_addr), 255);
    nx(3);
    chk("rdb_ack", 32'(m1.ack), 1);
    chk("rdb_rdata", m1.rdata, 32'h1234_5678);
    m1.req = 1'b0;
    nx(1);
    en_mark = en_cnt;
    m0.req = 1'b1; m0.we = 1'b0; m0.addr = 32'h1000;
    nx(1);
    chk("rej0_ack", 32'(m0.ack), 1);
    chk("rej0_err", 32'(m0.err), 1);
    chk("rej0_rdata", m0.rdata, 0);
    chk("rej0_busy", 32'(busy), 1);
    chk("rej0_m1_ack", 32'(m1.ack), 0);
    m0.addr = 32'h2;
    nx(1);
    chk("rej_idle_ack", 32'(m0.ack), 0);
    nx(1);
    chk("rej1_ack", 32'(m0.ack), 1);
    chk("rej1_err", 32'(m0.err), 1);
    chk("rej1_rdata", m0.rdata, 0);
    m0.req = 1'b0;
    nx(1);
    chk("rej_no_mem_en", en_cnt - en_mark, 0);
    m0.addr = 32'h10;
    m0.req = 1'b1;
    nx(1);
    chk("mid_mem_en", 32'(mem_en), 1);
    nx(1);
    rst = 1'b0;
    nx(1);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ack", 32'(m0.ack), 0);
    chk("mid_rst_mem_en", 32'(mem_en), 0);
    chk("mid_rst_rdata", m0.rdata, 0);
    rst = 1'b1;
    nx(1);
    chk("regrant_mem_en", 32'(mem_en), 1);
    chk("regrant_mem_addr", 32'(mem_addr), 4);
    chk("regrant_no_ack", 32'(m0.ack), 0);
    nx(3);
    chk("regrant_ack", 32'(m0.ack), 1);
    chk("regrant_rdata", m0.rdata, 32'hDEAD_BEEF);
    m0.req = 1'b0;
    nx(1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
